divider: RTL and testbench

- Sequential integer divider; the inverse of the existing Booth multiplier.
- Computes A / B: quotient on Lo, remainder on Hi (MIPS DIV/DIVU convention). Feeds the same Hi/Lo registers path in the ALU/control datapath.
- Uses a start/done handshake so the control unit can stall while a division runs.
- Restoring algorithm on magnitudes, one quotient bit per clock.

---
 rtl/divider_pkg.sv | 16 +
 rtl/div_step.sv | 30 +++
 rtl/divider.sv | 131 +++++++++++++
 tb/tb_divider.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: default width, FSM state
// encoding and the iteration-counter width.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Counter must hold WIDTH itself, hence one bit above clog2.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quot} left,
// trial-subtract the divisor at WIDTH+1 bits, keep the result if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the shifted remainder fits in WIDTH+1 bits and
  // a non-negative trial always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[WIDTH]) begin
      rem_next  = shifted[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end else begin
      rem_next  = trial[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Lo = quotient, Hi = remainder. Define DIVIDER_SIGNED_EN for signed (DIV)
// semantics; otherwise operands are unsigned (DIVU) and no negation exists.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state, nstate;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quot, dvs;
  logic [WIDTH-1:0] rem_n, quot_n;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg, r_neg;

  // Magnitudes of two's-complement operands; -MIN wraps to MIN, which is
  // exactly the unsigned magnitude we need.
  always_comb begin
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;
  end

  // Truncate toward zero; remainder follows the dividend's sign.
  always_comb begin
    fix_lo = q_neg ? -quot : quot;
    fix_hi = r_neg ? -rem  : rem;
  end
`else
  // Unsigned: operands pass straight through, writeback is unmodified.
  always_comb begin
    a_mag  = A;
    b_mag  = B;
    fix_lo = quot;
    fix_hi = rem;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (dvs),
    .rem_next  (rem_n),
    .quot_next (quot_n)
  );

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Next-state logic; a zero divisor completes without leaving IDLE.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start && (B != '0)) nstate = RUN;
      RUN:     if (cnt == CW'(1))      nstate = FIX;
      FIX:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, writeback and completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      dvs      <= '0;
      Hi       <= '0;
      Lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvs  <= b_mag;
          quot <= a_mag;
          rem  <= '0;
`ifdef DIVIDER_SIGNED_EN
          q_neg <= A[WIDTH-1] ^ B[WIDTH-1];
          r_neg <= A[WIDTH-1];
`endif
          if (B == '0) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else begin
            cnt <= CW'(WIDTH);
          end
        end
        RUN: begin
          rem  <= rem_n;
          quot <= quot_n;
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          Hi   <= fix_hi;
          Lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider. Signed vectors are exercised
// when DIVIDER_SIGNED_EN is defined for the build.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] A, B;
  logic        busy, done, div_zero;
  logic [31:0] Hi, Lo;

  int n_cmp = 0;
  int n_bad = 0;

  divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .div_zero(div_zero), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  // Launch one division; lat counts negedges after the start edge until done.
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic zf);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    zf = div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0 || div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got %b%b want 00", done, div_zero); end
    n_cmp++; if (Hi !== 32'd0 || Lo !== 32'd0) begin n_bad++; $display("FAIL reset_hilo got %h/%h want 0/0", Hi, Lo); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic zf;
    launch(32'd100, 32'd7, lat, zf);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL basic_latency got %0d want 33", lat); end
    n_cmp++; if (Lo !== 32'd14 || Hi !== 32'd2) begin n_bad++; $display("FAIL basic_100_7 got Lo=%0d Hi=%0d want 14 2", Lo, Hi); end
    n_cmp++; if (zf !== 1'b0) begin n_bad++; $display("FAIL basic_divzero got %b want 0", zf); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_large();
    int lat; logic zf;
    launch(32'hFFFF_FFFF, 32'h10, lat, zf);
`ifdef DIVIDER_SIGNED_EN
    // -1 / 16 truncates to 0, remainder -1.
    n_cmp++; if (Lo !== 32'd0 || Hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL large got Lo=%h Hi=%h want 0 ffffffff", Lo, Hi); end
`else
    n_cmp++; if (Lo !== 32'h0FFF_FFFF || Hi !== 32'hF) begin n_bad++; $display("FAIL large got Lo=%h Hi=%h want 0fffffff f", Lo, Hi); end
`endif
    launch(32'd5, 32'd9, lat, zf);
    n_cmp++; if (Lo !== 32'd0 || Hi !== 32'd5) begin n_bad++; $display("FAIL small_5_9 got Lo=%0d Hi=%0d want 0 5", Lo, Hi); end
  endtask

  task automatic test_div_zero();
    int lat; logic zf;
    launch(32'd100, 32'd7, lat, zf);
    launch(32'd5, 32'd0, lat, zf);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL dz_latency got %0d want 0", lat); end
    n_cmp++; if (zf !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", zf); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dz_busy got %b want 0", busy); end
    n_cmp++; if (Lo !== 32'd14 || Hi !== 32'd2) begin n_bad++; $display("FAIL dz_hold got Lo=%0d Hi=%0d want 14 2", Lo, Hi); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL dz_after got %b%b%b want 000", done, div_zero, busy); end
  endtask

  task automatic test_reset_mid();
    int lat; logic zf; int seen;
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctl got busy=%b done=%b want 0 0", busy, done); end
    n_cmp++; if (Hi !== 32'd0 || Lo !== 32'd0) begin n_bad++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", Hi, Lo); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_no_done got %0d pulses want 0", seen); end
    launch(32'd9, 32'd3, lat, zf);
    n_cmp++; if (Lo !== 32'd3 || Hi !== 32'd0 || lat !== 33) begin n_bad++; $display("FAIL rst_mid_next got Lo=%0d Hi=%0d lat=%0d want 3 0 33", Lo, Hi, lat); end
  endtask

  task automatic test_start_while_busy();
    int pulses; logic [31:0] lo_c, hi_c;
    pulses = 0; lo_c = '0; hi_c = '0;
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    A = 32'd1; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (done) begin pulses++; lo_c = Lo; hi_c = Hi; end
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL busy_start_pulses got %0d want 1", pulses); end
    n_cmp++; if (lo_c !== 32'd14 || hi_c !== 32'd2) begin n_bad++; $display("FAIL busy_start_result got Lo=%0d Hi=%0d want 14 2", lo_c, hi_c); end
  endtask

  task automatic test_back_to_back();
    int gap;
    int lat;
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    // Operands after the accepted edge only matter for the next launch.
    A = 32'd9; B = 32'd3;
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    n_cmp++; if (Lo !== 32'd14 || Hi !== 32'd2 || lat !== 33) begin n_bad++; $display("FAIL b2b_first got Lo=%0d Hi=%0d lat=%0d want 14 2 33", Lo, Hi, lat); end
    gap = 0;
    @(negedge clk); gap++;
    while (!done && gap < 100) begin @(negedge clk); gap++; end
    start = 1'b0;
    n_cmp++; if (gap !== 34) begin n_bad++; $display("FAIL b2b_gap got %0d want 34", gap); end
    n_cmp++; if (Lo !== 32'd3 || Hi !== 32'd0) begin n_bad++; $display("FAIL b2b_second got Lo=%0d Hi=%0d want 3 0", Lo, Hi); end
    repeat (40) @(negedge clk);
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    int lat; logic zf;
    launch(32'hFFFF_FFF9, 32'd2, lat, zf);
    n_cmp++; if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL s_m7_2 got Lo=%h Hi=%h want fffffffd ffffffff", Lo, Hi); end
    launch(32'd7, 32'hFFFF_FFFE, lat, zf);
    n_cmp++; if (Lo !== 32'hFFFF_FFFD || Hi !== 32'd1) begin n_bad++; $display("FAIL s_7_m2 got Lo=%h Hi=%h want fffffffd 1", Lo, Hi); end
    launch(32'h8000_0000, 32'hFFFF_FFFF, lat, zf);
    n_cmp++; if (Lo !== 32'h8000_0000 || Hi !== 32'd0 || zf !== 1'b0) begin n_bad++; $display("FAIL s_min_m1 got Lo=%h Hi=%h z=%b want 80000000 0 0", Lo, Hi, zf); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    test_reset();
    test_basic();
    test_large();
    test_div_zero();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
